// File: rtl/tdm_pkg.sv
// Shared widths and width helpers for the TDM splitter.
package tdm_pkg;

    localparam int unsigned DEF_NCH        = 4;
    localparam int unsigned DEF_DW         = 8;
    localparam int unsigned DEF_CW         = 8;
    localparam int unsigned DEF_SUB_PERIOD = 13;

    // Channel-index width: never below one bit, even for tiny channel counts.
    function automatic int unsigned ciw_of(input int unsigned nch);
        return (nch > 2) ? $clog2(nch) : 1;
    endfunction

    // Sub-counter width for a given modulus.
    function automatic int unsigned sw_of(input int unsigned period);
        return (period > 2) ? $clog2(period) : 1;
    endfunction

endpackage

// File: rtl/tdm_next_chan.sv
// Round-robin search for the nearest enabled channel after chan; falls back to chan+1 when none are enabled.
module tdm_next_chan
    import tdm_pkg::*;
#(
    parameter int unsigned NCH = DEF_NCH,
    parameter int unsigned CIW = ciw_of(DEF_NCH)
) (
    input  logic [NCH-1:0] ch_en,
    input  logic [CIW-1:0] chan,
    output logic [CIW-1:0] next_chan
);

    logic [CIW-1:0] cand;
    logic           found;

    always_comb begin
        cand      = '0;
        found     = 1'b0;
        next_chan = (chan == CIW'(NCH - 1)) ? '0 : chan + CIW'(1);
        // i == NCH revisits chan itself, so a lone enabled channel keeps the bus.
        for (int unsigned i = 1; i <= NCH; i++) begin
            cand = CIW'((32'(chan) + i) % NCH);
            if (!found && ch_en[cand]) begin
                found     = 1'b1;
                next_chan = cand;
            end
        end
    end

endmodule

// File: rtl/tdm_splitter.sv
// TDM splitter: walks NCH channel slots of programmable length and forwards the active channel's data.
// Build option: define TDM_SKIP_DISABLED_EN to skip disabled channels when advancing.
module tdm_splitter
    import tdm_pkg::*;
#(
    parameter int unsigned NCH        = DEF_NCH,
    parameter int unsigned DW         = DEF_DW,
    parameter int unsigned CW         = DEF_CW,
    parameter int unsigned SUB_PERIOD = DEF_SUB_PERIOD,
    localparam int unsigned CIW       = ciw_of(NCH),
    localparam int unsigned SW        = sw_of(SUB_PERIOD)
) (
    input  logic              sysclk,
    input  logic              rst,
    input  logic              run,
    input  logic [NCH-1:0]    ch_en,
    input  logic [NCH*CW-1:0] slot_len,
    input  logic [NCH*DW-1:0] din,
    output logic [DW-1:0]     dout,
    output logic              dout_valid,
    output logic [CIW-1:0]    chan,
    output logic [CW-1:0]     count,
    output logic [SW-1:0]     sub_count,
    output logic              slot_start,
    output logic              frame_start
);

    logic [CW-1:0]  cur_len;
    logic [DW-1:0]  cur_din;
    logic           cur_en;
    logic [NCH-1:0] search_mask;
    logic [CIW-1:0] next_chan;

    logic [CIW-1:0] chan_d;
    logic [CW-1:0]  count_d;
    logic [SW-1:0]  sub_count_d;
    logic [DW-1:0]  dout_d;
    logic           dout_valid_d;
    logic           slot_start_d;
    logic           frame_start_d;

    // An all-ones mask makes the search degenerate to plain chan+1 mod NCH.
`ifdef TDM_SKIP_DISABLED_EN
    assign search_mask = ch_en;
`else
    assign search_mask = '1;
`endif

    tdm_next_chan #(
        .NCH (NCH),
        .CIW (CIW)
    ) u_next_chan (
        .ch_en     (search_mask),
        .chan      (chan),
        .next_chan (next_chan)
    );

    // Select the current channel's slot length and data.
    always_comb begin
        cur_len = '0;
        cur_din = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (chan == CIW'(k)) begin
                cur_len = slot_len[k*CW +: CW];
                cur_din = din[k*DW +: DW];
            end
        end
        cur_en = ch_en[chan];
    end

    always_comb begin
        chan_d        = chan;
        count_d       = count;
        sub_count_d   = sub_count;
        dout_d        = '0;
        dout_valid_d  = 1'b0;
        slot_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (run) begin
            sub_count_d = (sub_count == SW'(SUB_PERIOD - 1)) ? '0 : sub_count + SW'(1);
            // >= lets a shortened slot length end the slot immediately.
            if (count >= cur_len) begin
                count_d       = '0;
                chan_d        = next_chan;
                slot_start_d  = 1'b1;
                frame_start_d = (next_chan <= chan);
            end else begin
                count_d = count + CW'(1);
            end
            if (cur_en) begin
                dout_d       = cur_din;
                dout_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            chan        <= '0;
            count       <= '0;
            sub_count   <= '0;
            dout        <= '0;
            dout_valid  <= 1'b0;
            slot_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            chan        <= chan_d;
            count       <= count_d;
            sub_count   <= sub_count_d;
            dout        <= dout_d;
            dout_valid  <= dout_valid_d;
            slot_start  <= slot_start_d;
            frame_start <= frame_start_d;
        end
    end

endmodule

// File: tb/tb_tdm_splitter.sv
// Directed self-checking bench for tdm_splitter (default build, NCH=4, DW=8, CW=8, SUB_PERIOD=13).
module tb_tdm_splitter;

    logic        sysclk;
    logic        rst;
    logic        run;
    logic [3:0]  ch_en;
    logic [31:0] slot_len;
    logic [31:0] din;
    logic [7:0]  dout;
    logic        dout_valid;
    logic [1:0]  chan;
    logic [7:0]  count;
    logic [3:0]  sub_count;
    logic        slot_start;
    logic        frame_start;

    int n_checks = 0;
    int n_fails  = 0;
    int sub_exp  = 0;

    tdm_splitter #(
        .NCH        (4),
        .DW         (8),
        .CW         (8),
        .SUB_PERIOD (13)
    ) dut (
        .sysclk      (sysclk),
        .rst         (rst),
        .run         (run),
        .ch_en       (ch_en),
        .slot_len    (slot_len),
        .din         (din),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .chan        (chan),
        .count       (count),
        .sub_count   (sub_count),
        .slot_start  (slot_start),
        .frame_start (frame_start)
    );

    initial begin
        sysclk = 1'b0;
        forever #5 sysclk = ~sysclk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    // Advance n edges; inputs change and outputs are sampled 1 time unit after each edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge sysclk);
            #1;
            if (rst)      sub_exp = 0;
            else if (run) sub_exp = (sub_exp + 1) % 13;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst      = 1'b1;
        run      = 1'b0;
        ch_en    = 4'hF;
        slot_len = {8'd43, 8'd76, 8'd109, 8'd142};
        din      = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        step(2);
        chk("rst_chan", 32'(chan), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_sub", 32'(sub_count), 0);
        chk("rst_dout", 32'(dout), 0);
        chk("rst_valid", 32'(dout_valid), 0);
        chk("rst_pulses", {30'd0, slot_start, frame_start}, 0);

        // Full frame with all channels enabled: slots of 143/110/77/44 cycles.
        rst = 1'b0;
        run = 1'b1;
        step(1);
        chk("first_count", 32'(count), 1);
        chk("first_chan", 32'(chan), 0);
        chk("first_nopulse", {30'd0, slot_start, frame_start}, 0);
        chk("first_dout", 32'(dout), 32'hA0);
        chk("first_valid", 32'(dout_valid), 1);
        step(142);
        chk("s1_chan", 32'(chan), 1);
        chk("s1_count", 32'(count), 0);
        chk("s1_pulses", {30'd0, slot_start, frame_start}, 32'b10);
        step(1);
        chk("s1_dout", 32'(dout), 32'hA1);
        chk("s1_pulse_off", 32'(slot_start), 0);
        step(109);
        chk("s2_chan", 32'(chan), 2);
        step(77);
        chk("s3_chan", 32'(chan), 3);
        step(44);
        chk("frame_chan", 32'(chan), 0);
        chk("frame_pulses", {30'd0, slot_start, frame_start}, 32'b11);
        chk("frame_sub", 32'(sub_count), 10);
        chk("frame_dout", 32'(dout), 32'hA3);

        // Disabled channels are still visited but produce zero data.
        ch_en = 4'b1010;
        step(1);
        chk("dis0_dout", 32'(dout), 0);
        chk("dis0_valid", 32'(dout_valid), 0);
        chk("dis0_count", 32'(count), 1);
        step(142);
        chk("dis1_chan", 32'(chan), 1);
        step(1);
        chk("en1_dout", 32'(dout), 32'hA1);
        chk("en1_valid", 32'(dout_valid), 1);
        step(109);
        chk("dis2_chan", 32'(chan), 2);
        step(1);
        chk("dis2_dout", 32'(dout), 0);
        chk("dis2_valid", 32'(dout_valid), 0);

        // Pause at count 50 for 20 cycles.
        step(49);
        chk("pre_pause_count", 32'(count), 50);
        run   = 1'b0;
        ch_en = 4'hF;
        step(20);
        chk("pause_count", 32'(count), 50);
        chk("pause_chan", 32'(chan), 2);
        chk("pause_sub", 32'(sub_count), 32'(sub_exp));
        chk("pause_dout", 32'(dout), 0);
        chk("pause_valid", 32'(dout_valid), 0);
        chk("pause_pulses", {30'd0, slot_start, frame_start}, 0);
        run = 1'b1;
        step(1);
        chk("resume_count", 32'(count), 51);
        chk("resume_dout", 32'(dout), 32'hA2);
        chk("resume_sub", 32'(sub_count), 32'(sub_exp));
        step(25);
        chk("s2_last_count", 32'(count), 76);
        step(1);
        chk("s3b_chan", 32'(chan), 3);
        chk("s3b_pulses", {30'd0, slot_start, frame_start}, 32'b10);

        // Slot length lowered below the current count ends the slot next cycle.
        slot_len[24 +: 8] = 8'd100;
        step(40);
        chk("long_count", 32'(count), 40);
        slot_len[24 +: 8] = 8'd10;
        step(1);
        chk("short_chan", 32'(chan), 0);
        chk("short_count", 32'(count), 0);
        chk("short_pulses", {30'd0, slot_start, frame_start}, 32'b11);

        // slot_len = 0 gives a one-cycle slot.
        slot_len[0 +: 8] = 8'd0;
        step(1);
        chk("zero_chan", 32'(chan), 1);
        chk("zero_pulses", {30'd0, slot_start, frame_start}, 32'b10);

        // Reset coincident with a slot end wins.
        slot_len[8 +: 8] = 8'd0;
        rst = 1'b1;
        step(1);
        chk("rstend_chan", 32'(chan), 0);
        chk("rstend_count", 32'(count), 0);
        chk("rstend_sub", 32'(sub_count), 0);
        chk("rstend_pulses", {30'd0, slot_start, frame_start}, 0);
        chk("rstend_dout", {23'd0, dout_valid, dout}, 0);

        // Sub-counter runs 0..12 over 26 cycles across 3-cycle slots.
        rst      = 1'b0;
        slot_len = {8'd2, 8'd2, 8'd2, 8'd2};
        step(1);
        chk("post_rst_count", 32'(count), 1);
        chk("post_rst_chan", 32'(chan), 0);
        chk("post_rst_nopulse", {30'd0, slot_start, frame_start}, 0);
        chk("sub_1", 32'(sub_count), 1);
        for (int i = 2; i <= 26; i++) begin
            step(1);
            chk("sub_seq", 32'(sub_count), 32'(i % 13));
        end
        chk("sub_end_chan", 32'(chan), 0);
        chk("sub_end_count", 32'(count), 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/tdm_splitter.md
TDM_SPLITTER -- requirements
Module: tdm_splitter

Interface
REQ-001 SHALL have parameter NCH, default 4, number of time-multiplexed input channels (2..16).
REQ-002 SHALL have parameter DW, default 8, data width per channel.
REQ-003 SHALL have parameter CW, default 8, slot counter width.
REQ-004 SHALL have parameter SUB_PERIOD, default 13, modulus of the free-running sub-counter (2..2**SW).
REQ-005 SHALL have port sysclk, input, 1, the single clock; all logic rises on posedge sysclk.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port run, input, 1, high = advance; low = pause.
REQ-008 SHALL have port ch_en, input, NCH, per-channel output enable.
REQ-009 SHALL have port slot_len, input, NCH*CW, packed per-channel terminal count (slot lasts value+1 cycles); channel k occupies bits [k*CW +: CW].
REQ-010 SHALL have port din, input, NCH*DW, packed channel data; channel k occupies bits [k*DW +: DW].
REQ-011 SHALL have port dout, output, DW, registered selected data.
REQ-012 SHALL have port dout_valid, output, 1, high when dout carries enabled-channel data.
REQ-013 SHALL have port chan, output, CIW=max(1,clog2(NCH)), current slot channel index.
REQ-014 SHALL have port count, output, CW, cycle position within current slot.
REQ-015 SHALL have port sub_count, output, SW=clog2(SUB_PERIOD), free-running sub-counter.
REQ-016 SHALL have ports slot_start and frame_start, output, 1 each, single-cycle pulses.

Function
REQ-017 SHALL, on each cycle with run=1, increment count, except that when count >= slot_len[chan] it SHALL clear count and advance chan to the next channel (REQ-021).
REQ-018 SHALL use >= for the slot end so that lowering slot_len below the current count ends the slot on the next cycle; slot_len=0 gives a 1-cycle slot.
REQ-019 SHALL wrap chan from NCH-1 to 0 and pulse frame_start for the cycle in which chan becomes 0 via a wrap.
REQ-020 SHALL pulse slot_start for the cycle in which count returns to 0 via a slot end.
REQ-021 SHALL define the next channel as chan+1 modulo NCH (see REQ-032 for the alternative).
REQ-022 SHALL, with run=1, register dout <= din[chan] and dout_valid <= 1 when ch_en[chan]=1, else dout <= 0 and dout_valid <= 0, using pre-update chan (one cycle latency).
REQ-023 SHALL increment sub_count each run=1 cycle, wrapping from SUB_PERIOD-1 to 0, independent of slot boundaries.
REQ-024 SHALL, with run=0, hold chan, count and sub_count, drive dout=0 and dout_valid=0, and suppress slot_start/frame_start; resuming continues from the held position.
REQ-025 SHALL evaluate ch_en every cycle; clearing ch_en mid-slot zeroes dout from the next cycle without shortening the slot.

Reset
REQ-026 SHALL, when rst=1 at a clock edge, set chan=0, count=0, sub_count=0, dout=0, dout_valid=0, slot_start=0, frame_start=0.
REQ-027 SHALL give rst priority over run and over any slot end occurring the same cycle.
REQ-028 SHALL start the first slot on channel 0 in the first run=1 cycle after reset, with no slot_start/frame_start pulse for that initial slot.

Configuration
REQ-029 SHALL use macro TDM_SKIP_DISABLED_EN to select the channel-advance policy.
REQ-030 SHALL, without TDM_SKIP_DISABLED_EN, visit every channel in order, including disabled ones.
REQ-031 SHALL, with TDM_SKIP_DISABLED_EN, advance at slot end to the nearest enabled channel after chan in round-robin order, possibly chan itself if it is the only one enabled.
REQ-032 SHALL, with TDM_SKIP_DISABLED_EN and ch_en all zero, fall back to chan+1 modulo NCH.
REQ-033 SHALL, with TDM_SKIP_DISABLED_EN, pulse frame_start when the advance wraps past index NCH-1 or lands on an index <= chan.

Structure
REQ-034 SHALL place the width helper (clog2-based CIW/SW derivation) and the slot-record field widths in shared package tdm_pkg.
REQ-035 SHALL isolate the combinational round-robin next-enabled-channel search in sub-module tdm_next_chan (inputs: ch_en, chan; output: next index).

Verification
REQ-036 SHALL cover: NCH=4, slot_len={142,109,76,43}, all enabled -> slots of 143/110/77/44 cycles in order 0,1,2,3, frame_start every 374 cycles.
REQ-037 SHALL cover: ch_en=4'b1010 without macro -> dout=0 and dout_valid=0 during slots 0 and 2; with macro -> chan alternates 1,3 only.
REQ-038 SHALL cover: run low for 20 cycles at count=50 -> count, chan and sub_count frozen, dout=0, then the sequence resumes at count=51.
REQ-039 SHALL cover: slot_len[chan] changed from 100 to 10 while count=40 -> slot ends next cycle, slot_start pulses.
REQ-040 SHALL cover: rst asserted coincident with a slot end -> all outputs 0, chan=0, no pulses.
REQ-041 SHALL cover: sub_count sequence 0..12,0 over 26 run cycles, unaffected by slot boundaries.
